waterfall_line_writer: RTL and testbench

//  Downstream consumer of the SDFT magnitude port. On each line_tick it drives the

---
 rtl/waterfall_line_writer.sv | 186 ++++++++++++++++++
 tb/tb_waterfall_line_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/waterfall_line_writer.sv
// Waterfall line writer: on each line tick, reads every SDFT bin through the
// read/bin_addr handshake, then gain-scales and saturates each magnitude to a
// pixel. Each pixel is written into one row of a circular framebuffer.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_line_tick         1-cycle request to capture a new line
//   i_gain              left shift applied to the magnitude (0..15)
//   i_sdft_ready        SDFT idle and able to accept a read
//   i_sdft_bin          SDFT magnitude for the addressed bin
//   o_sdft_read         SDFT read request
//   o_sdft_bin_addr     SDFT bin address
//   o_fb_we             framebuffer write strobe
//   o_fb_addr           framebuffer address {row, bin}
//   o_fb_data           pixel value
//   o_cur_row           last fully written row
//   o_line_done         1-cycle pulse after the last pixel of a line
//   o_overrun_cnt       dropped-tick count, saturating at 255
module waterfall_line_writer #(
  parameter int unsigned FREQ_W     = 16,
  parameter int unsigned LIMIT_BINS = 32,
  parameter int unsigned PIXEL_W    = 8,
  parameter int unsigned NUM_ROWS   = 32
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_line_tick,
  input  logic [3:0]                                    i_gain,
  input  logic                                          i_sdft_ready,
  input  logic [FREQ_W-1:0]                             i_sdft_bin,
  output logic                                          o_sdft_read,
  output logic [$clog2(LIMIT_BINS)-1:0]                 o_sdft_bin_addr,
  output logic                                          o_fb_we,
  output logic [$clog2(NUM_ROWS)+$clog2(LIMIT_BINS)-1:0] o_fb_addr,
  output logic [PIXEL_W-1:0]                            o_fb_data,
  output logic [$clog2(NUM_ROWS)-1:0]                   o_cur_row,
  output logic                                          o_line_done,
  output logic [7:0]                                    o_overrun_cnt
);

  localparam int unsigned BIN_ADDR_W = $clog2(LIMIT_BINS);
  localparam int unsigned ROW_W      = $clog2(NUM_ROWS);
  localparam int unsigned FB_ADDR_W  = ROW_W + BIN_ADDR_W;
  localparam int unsigned CYC_W      = $clog2(LIMIT_BINS + 4) + 1;
  localparam int unsigned S_W        = FREQ_W + 15;

  // Cycle indices counted from the start edge: last address step, first and
  // last capture cycles (a capture at cycle n registers bin n-3).
  localparam logic [CYC_W-1:0] CYC_SWEEP_LAST = CYC_W'(LIMIT_BINS - 1);
  localparam logic [CYC_W-1:0] CYC_CAP_FIRST  = CYC_W'(3);
  localparam logic [CYC_W-1:0] CYC_CAP_LAST   = CYC_W'(LIMIT_BINS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state, w_state_nx;
  logic [CYC_W-1:0]        r_cyc, w_cyc_nx;
  logic                    r_pend, w_pend_nx;
  logic [ROW_W-1:0]        r_row, w_row_nx;
  logic                    r_read, w_read_nx;
  logic [BIN_ADDR_W-1:0]   r_bin_addr, w_bin_addr_nx;
  logic                    r_fb_we, w_fb_we_nx;
  logic [FB_ADDR_W-1:0]    r_fb_addr, w_fb_addr_nx;
  logic [PIXEL_W-1:0]      r_fb_data, w_fb_data_nx;
  logic [ROW_W-1:0]        r_cur_row, w_cur_row_nx;
  logic                    r_line_done, w_line_done_nx;
  logic [7:0]              r_overrun, w_overrun_nx;

  logic                    w_idle;
  logic                    w_start;
  logic                    w_drop;
  logic                    w_capture;
  logic [S_W-1:0]          w_shifted;
  logic [PIXEL_W-1:0]      w_pixel;

  // Gain scaling with saturation to full-scale pixel.
  assign w_shifted = {15'b0, i_sdft_bin} << i_gain;
  assign w_pixel   = (|w_shifted[S_W-1:PIXEL_W]) ? {PIXEL_W{1'b1}} : w_shifted[PIXEL_W-1:0];

  // Tick bookkeeping: a tick landing on the consume cycle is re-latched.
  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_idle && r_pend && i_sdft_ready;
  assign w_drop    = i_line_tick && !w_start && (r_pend || !w_idle);
  assign w_capture = ((r_state == S_SWEEP) || (r_state == S_DRAIN)) && (r_cyc >= CYC_CAP_FIRST);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_cyc_nx       = r_cyc + CYC_W'(1);
    w_row_nx       = r_row;
    w_read_nx      = r_read;
    w_bin_addr_nx  = r_bin_addr;
    w_fb_we_nx     = 1'b0;
    w_fb_addr_nx   = r_fb_addr;
    w_fb_data_nx   = r_fb_data;
    w_cur_row_nx   = r_cur_row;
    w_line_done_nx = 1'b0;
    w_pend_nx      = w_start ? i_line_tick : (r_pend | (i_line_tick & w_idle));
    w_overrun_nx   = (w_drop && (r_overrun != 8'hFF)) ? r_overrun + 8'd1 : r_overrun;

    unique case (r_state)
      S_IDLE: begin
        w_cyc_nx = '0;
        if (w_start) begin
          w_state_nx    = S_REQ;
          w_read_nx     = 1'b1;
          w_bin_addr_nx = '0;
        end
      end
      S_REQ: begin
        w_state_nx = S_SWEEP;
      end
      S_SWEEP: begin
        w_bin_addr_nx = r_bin_addr + BIN_ADDR_W'(1);
        if (r_cyc == CYC_SWEEP_LAST) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cyc == CYC_CAP_LAST) begin
          w_read_nx  = 1'b0;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_line_done_nx = 1'b1;
        w_cur_row_nx   = r_row;
        w_row_nx       = r_row + ROW_W'(1);
        w_state_nx     = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_capture) begin
      w_fb_we_nx   = 1'b1;
      w_fb_addr_nx = {r_row, BIN_ADDR_W'(r_cyc - CYC_CAP_FIRST)};
      w_fb_data_nx = w_pixel;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_pend      <= 1'b0;
      r_row       <= '0;
      r_read      <= 1'b0;
      r_bin_addr  <= '0;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= '0;
      r_cur_row   <= '0;
      r_line_done <= 1'b0;
      r_overrun   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cyc       <= w_cyc_nx;
      r_pend      <= w_pend_nx;
      r_row       <= w_row_nx;
      r_read      <= w_read_nx;
      r_bin_addr  <= w_bin_addr_nx;
      r_fb_we     <= w_fb_we_nx;
      r_fb_addr   <= w_fb_addr_nx;
      r_fb_data   <= w_fb_data_nx;
      r_cur_row   <= w_cur_row_nx;
      r_line_done <= w_line_done_nx;
      r_overrun   <= w_overrun_nx;
    end
  end

  assign o_sdft_read     = r_read;
  assign o_sdft_bin_addr = r_bin_addr;
  assign o_fb_we         = r_fb_we;
  assign o_fb_addr       = r_fb_addr;
  assign o_fb_data       = r_fb_data;
  assign o_cur_row       = r_cur_row;
  assign o_line_done     = r_line_done;
  assign o_overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_waterfall_line_writer.sv
// Bench for waterfall_line_writer: behavioural SDFT with 2-edge read latency
// (|bin k| = 4k), scoreboard of expected framebuffer writes and line completions.
module tb_waterfall_line_writer;

  localparam int unsigned FREQ_W     = 16;
  localparam int unsigned LIMIT_BINS = 32;
  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned NUM_ROWS   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_tick = 1'b0;
  logic [3:0]  gain = 4'd0;
  logic        force_busy = 1'b0;
  logic        sdft_ready;
  logic [15:0] sdft_bin;
  logic        sdft_read;
  logic [4:0]  sdft_bin_addr;
  logic        fb_we;
  logic [6:0]  fb_addr;
  logic [7:0]  fb_data;
  logic [1:0]  cur_row;
  logic        line_done;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  waterfall_line_writer #(
    .FREQ_W(FREQ_W), .LIMIT_BINS(LIMIT_BINS), .PIXEL_W(PIXEL_W), .NUM_ROWS(NUM_ROWS)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_line_tick(line_tick), .i_gain(gain),
    .i_sdft_ready(sdft_ready), .i_sdft_bin(sdft_bin),
    .o_sdft_read(sdft_read), .o_sdft_bin_addr(sdft_bin_addr),
    .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_data(fb_data),
    .o_cur_row(cur_row), .o_line_done(line_done), .o_overrun_cnt(overrun_cnt)
  );

  // SDFT model: enters READ when it samples read, address sampled one edge
  // later, magnitude presented the edge after that.
  logic        m_read = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [15:0] m_bin  = 16'd0;
  always @(posedge clk) begin
    m_read <= sdft_read;
    m_addr <= sdft_bin_addr;
    m_bin  <= 16'(4 * m_addr);
  end
  assign sdft_ready = !force_busy && !m_read;
  assign sdft_bin   = m_bin;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  int   exp_done[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en = 1'b1;
  bit   chk_read_len = 1'b1;
  int   rise_cnt = 0;
  int   high_cnt = 0;
  logic prev_read = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes a pixel or ends a line.
  always @(negedge clk) begin
    wr_t e;
    int  r;
    if (sdft_read && !prev_read) begin
      rise_cnt = 0;
      high_cnt = 0;
    end else begin
      rise_cnt++;
    end
    if (sdft_read) high_cnt++;
    if (!sdft_read && prev_read && chk_read_len) check("read_len", high_cnt, 35);
    prev_read = sdft_read;

    if (sb_en && fb_we) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        e = exp_wr.pop_front();
        check("fb_addr", int'(fb_addr), int'(e.addr));
        check("fb_data", int'(fb_data), int'(e.data));
        check("we_timing", rise_cnt, int'(e.addr[4:0]) + 4);
      end
    end
    if (sb_en && line_done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        r = exp_done.pop_front();
        check("done_cur_row", int'(cur_row), r);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bins(input int row, input int g, input int nbins);
    wr_t e;
    int  v;
    for (int k = 0; k < nbins; k++) begin
      v = (4 * k) << g;
      if (v > 255) v = 255;
      e.addr = 7'(row * 32 + k);
      e.data = 8'(v);
      exp_wr.push_back(e);
    end
  endtask

  task automatic push_line(input int row, input int g);
    push_bins(row, g, 32);
    exp_done.push_back(row);
  endtask

  task automatic tick();
    line_tick = 1'b1;
    step(1);
    line_tick = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) check("drain_timeout", exp_wr.size() + exp_done.size(), 0);
    step(2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_read"},      int'(sdft_read), 0);
    check({tag, "_bin_addr"},  int'(sdft_bin_addr), 0);
    check({tag, "_fb_we"},     int'(fb_we), 0);
    check({tag, "_fb_addr"},   int'(fb_addr), 0);
    check({tag, "_fb_data"},   int'(fb_data), 0);
    check({tag, "_cur_row"},   int'(cur_row), 0);
    check({tag, "_line_done"}, int'(line_done), 0);
    check({tag, "_overrun"},   int'(overrun_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step(2);
    check_zero(tag);
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    int n;
    step(3);
    check_zero("por");
    reset = 1'b0;
    step(2);

    // Basic line, gain 0, row 0.
    gain = 4'd0;
    push_line(0, 0);
    tick();
    wait_drain(200);
    check("t1_cur_row", int'(cur_row), 0);
    check("t1_overrun", int'(overrun_cnt), 0);

    // Saturation with gain 3, row 1.
    gain = 4'd3;
    push_line(1, 3);
    tick();
    wait_drain(200);
    check("t2_cur_row", int'(cur_row), 1);

    // Row wrap over the 4-row ring after a fresh reset.
    do_reset("rst3");
    gain = 4'd1;
    for (int i = 0; i < 5; i++) begin
      push_line(i % 4, 1);
      tick();
      step(59);
    end
    wait_drain(200);
    check("t3_cur_row", int'(cur_row), 0);

    // Busy SDFT holds off the read until ready rises.
    gain = 4'd2;
    push_line(1, 2);
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      check("t4_read_held", int'(sdft_read), 0);
      step(1);
    end
    force_busy = 1'b0;
    wait_drain(200);
    check("t4_overrun", int'(overrun_cnt), 0);
    check("t4_cur_row", int'(cur_row), 1);

    // Three back-to-back ticks: one runs, one pending, one dropped.
    gain = 4'd0;
    push_line(2, 0);
    push_line(3, 0);
    line_tick = 1'b1;
    step(3);
    line_tick = 1'b0;
    wait_drain(300);
    check("t5_overrun", int'(overrun_cnt), 1);
    check("t5_cur_row", int'(cur_row), 3);

    // Long tick burst saturates the overrun counter.
    sb_en = 1'b0;
    line_tick = 1'b1;
    step(320);
    line_tick = 1'b0;
    check("t5_overrun_sat", int'(overrun_cnt), 255);
    step(120);
    check("t5_overrun_hold", int'(overrun_cnt), 255);
    do_reset("rst6");
    exp_wr.delete();
    exp_done.delete();
    sb_en = 1'b1;

    // Reset mid-line at bin 10, then a clean restart at row 0, bin 0.
    gain = 4'd0;
    push_bins(0, 0, 10);
    chk_read_len = 1'b0;
    tick();
    n = 0;
    while (!(fb_we && fb_addr[4:0] == 5'd9) && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) check("t6_bin9_timeout", n, 0);
    reset = 1'b1;
    step(1);
    check_zero("t6_abort");
    reset = 1'b0;
    step(15);
    chk_read_len = 1'b1;
    check("t6_leftover", exp_wr.size(), 0);
    push_line(0, 0);
    tick();
    wait_drain(200);
    check("t6_cur_row", int'(cur_row), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
